// File: rtl/dfii_init_sequencer_pkg.sv
// ============================================================================
// Module   : dfii_init_sequencer_pkg
// Brief    : Shared DFII register map, bit fields and step-entry types.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dfii_init_sequencer_pkg;

    localparam logic [31:0] DFII_BASE_DEF   = 32'h0000_9000;
    localparam logic [13:0] MR0_DLLRST_DEF  = 14'h320;
    localparam logic [13:0] MR0_DEF         = 14'h220;
    localparam logic [13:0] MR1_DEF         = 14'h006;
    localparam logic [13:0] MR2_DEF         = 14'h200;
    localparam logic [13:0] MR3_DEF         = 14'h000;
    localparam logic [23:0] T_RESET_DEF     = 24'd50;
    localparam logic [23:0] T_CKE_DEF       = 24'd50;
    localparam logic [23:0] T_DLLK_DEF      = 24'd600;
    localparam logic [23:0] T_ZQINIT_DEF    = 24'd600;
    localparam logic [15:0] ACK_TIMEOUT_DEF = 16'd1024;

    localparam logic [4:0]  LAST_STEP = 5'd28;

    // Register select doubles as the word offset from DFII_BASE
    typedef enum logic [2:0] {
        REG_CONTROL  = 3'd0,
        REG_COMMAND  = 3'd1,
        REG_ISSUE    = 3'd2,
        REG_ADDRESS  = 3'd3,
        REG_BADDRESS = 3'd4
    } dfii_reg_e;

    localparam logic [31:0] CTRL_SEL     = 32'h01;
    localparam logic [31:0] CTRL_CKE     = 32'h02;
    localparam logic [31:0] CTRL_ODT     = 32'h04;
    localparam logic [31:0] CTRL_RESET_N = 32'h08;

    localparam logic [31:0] CMD_CS  = 32'h01;
    localparam logic [31:0] CMD_WE  = 32'h02;
    localparam logic [31:0] CMD_CAS = 32'h04;
    localparam logic [31:0] CMD_RAS = 32'h08;

    localparam logic [31:0] CMD_MRS   = CMD_CS | CMD_WE | CMD_CAS | CMD_RAS;
    localparam logic [31:0] CMD_ZQCL  = CMD_CS | CMD_WE;
    localparam logic [31:0] ISSUE_GO  = 32'h01;
    localparam logic [31:0] ZQCL_ADDR = 32'h400;

    typedef enum logic [1:0] {
        WAIT_NONE      = 2'd0,
        WAIT_RESET_CKE = 2'd1,
        WAIT_DLLK      = 2'd2,
        WAIT_ZQINIT    = 2'd3
    } wait_sel_e;

    typedef struct packed {
        dfii_reg_e   sel;
        logic [31:0] data;
        wait_sel_e   wait_sel;
    } step_entry_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_GAP   = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } seq_state_e;

    function automatic logic [29:0] reg_word_adr(input logic [31:0] base, input dfii_reg_e sel);
        logic [31:0] byte_adr;
        byte_adr = base + {27'd0, sel, 2'b00};
        return byte_adr[31:2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dfii_init_sequencer_rom.sv
// ============================================================================
// Module   : dfii_init_rom
// Brief    : Combinational step index to DFII write entry lookup.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dfii_init_rom
    import dfii_init_sequencer_pkg::*;
#(
    parameter logic [13:0] MR0_DLLRST = MR0_DLLRST_DEF,
    parameter logic [13:0] MR0        = MR0_DEF,
    parameter logic [13:0] MR1        = MR1_DEF,
    parameter logic [13:0] MR2        = MR2_DEF,
    parameter logic [13:0] MR3        = MR3_DEF
) (
    input  logic [4:0]  i_step,
    output step_entry_t o_entry
);

    logic [4:0]  w_mrs_off;
    logic [13:0] w_mr_val;
    logic [1:0]  w_ba;

    always_comb begin
        // MRS writes occupy steps 4..23, four writes per mode register
        w_mrs_off = i_step - 5'd4;
        w_mr_val  = 14'd0;
        w_ba      = 2'd0;
        case (w_mrs_off[4:2])
            3'd0:    begin w_mr_val = MR2;        w_ba = 2'd2; end
            3'd1:    begin w_mr_val = MR3;        w_ba = 2'd3; end
            3'd2:    begin w_mr_val = MR1;        w_ba = 2'd1; end
            3'd3:    begin w_mr_val = MR0_DLLRST; w_ba = 2'd0; end
            default: begin w_mr_val = MR0;        w_ba = 2'd0; end
        endcase
    end

    always_comb begin
        o_entry.sel      = REG_ADDRESS;
        o_entry.data     = 32'd0;
        o_entry.wait_sel = WAIT_NONE;
        if (i_step < 5'd4) begin
            case (i_step[1:0])
                2'd0: o_entry.sel = REG_ADDRESS;
                2'd1: o_entry.sel = REG_BADDRESS;
                2'd2: begin
                    o_entry.sel      = REG_CONTROL;
                    o_entry.data     = CTRL_ODT | CTRL_RESET_N;
                    o_entry.wait_sel = WAIT_RESET_CKE;
                end
                default: begin
                    o_entry.sel      = REG_CONTROL;
                    o_entry.data     = CTRL_ODT | CTRL_RESET_N | CTRL_CKE;
                    o_entry.wait_sel = WAIT_RESET_CKE;
                end
            endcase
        end else if (i_step < 5'd24) begin
            case (w_mrs_off[1:0])
                2'd0: begin
                    o_entry.sel  = REG_ADDRESS;
                    o_entry.data = {18'd0, w_mr_val};
                end
                2'd1: begin
                    o_entry.sel  = REG_BADDRESS;
                    o_entry.data = {30'd0, w_ba};
                end
                2'd2: begin
                    o_entry.sel  = REG_COMMAND;
                    o_entry.data = CMD_MRS;
                end
                default: begin
                    o_entry.sel      = REG_ISSUE;
                    o_entry.data     = ISSUE_GO;
                    o_entry.wait_sel = (i_step == 5'd23) ? WAIT_DLLK : WAIT_NONE;
                end
            endcase
        end else if (i_step < LAST_STEP) begin
            case (i_step[1:0])
                2'd0: begin
                    o_entry.sel  = REG_ADDRESS;
                    o_entry.data = ZQCL_ADDR;
                end
                2'd1: o_entry.sel = REG_BADDRESS;
                2'd2: begin
                    o_entry.sel  = REG_COMMAND;
                    o_entry.data = CMD_ZQCL;
                end
                default: begin
                    o_entry.sel      = REG_ISSUE;
                    o_entry.data     = ISSUE_GO;
                    o_entry.wait_sel = WAIT_ZQINIT;
                end
            endcase
        end else begin
            o_entry.sel  = REG_CONTROL;
            o_entry.data = CTRL_SEL;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dfii_init_sequencer.sv
// ============================================================================
// Module   : dfii_init_sequencer
// Brief    : DDR3 power-up sequencer driving the DFII CSRs over Wishbone classic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dfii_init_sequencer
    import dfii_init_sequencer_pkg::*;
#(
    parameter logic [31:0] DFII_BASE   = DFII_BASE_DEF,
    parameter logic [13:0] MR0_DLLRST  = MR0_DLLRST_DEF,
    parameter logic [13:0] MR0         = MR0_DEF,
    parameter logic [13:0] MR1         = MR1_DEF,
    parameter logic [13:0] MR2         = MR2_DEF,
    parameter logic [13:0] MR3         = MR3_DEF,
    parameter logic [23:0] T_RESET     = T_RESET_DEF,
    parameter logic [23:0] T_CKE       = T_CKE_DEF,
    parameter logic [23:0] T_DLLK      = T_DLLK_DEF,
    parameter logic [23:0] T_ZQINIT    = T_ZQINIT_DEF,
    parameter logic [15:0] ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [4:0]  o_step,
    output logic [29:0] o_wb_adr,
    output logic [31:0] o_wb_dat_w,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    input  logic        i_wb_ack
);

    seq_state_e  r_state;
    seq_state_e  w_state_nxt;
    logic [4:0]  r_step;
    logic [4:0]  w_step_nxt;
    logic        w_load_req;
    logic [29:0] r_wb_adr;
    logic [31:0] r_wb_dat;
    wait_sel_e   r_wait_sel;
    logic [23:0] r_wait;
    logic [23:0] w_wait_val;
    logic [15:0] r_timeout;
    logic        w_timeout_hit;
    step_entry_t w_entry;

    // Indexed by the step about to be requested so the bus fields register on REQ entry
    dfii_init_rom #(
        .MR0_DLLRST (MR0_DLLRST),
        .MR0        (MR0),
        .MR1        (MR1),
        .MR2        (MR2),
        .MR3        (MR3)
    ) u_rom (
        .i_step  (w_step_nxt),
        .o_entry (w_entry)
    );

    assign w_timeout_hit = (r_timeout >= (ACK_TIMEOUT - 16'd1));

    always_comb begin
        case (r_wait_sel)
            WAIT_RESET_CKE: w_wait_val = r_step[0] ? T_CKE : T_RESET;
            WAIT_DLLK:      w_wait_val = T_DLLK;
            WAIT_ZQINIT:    w_wait_val = T_ZQINIT;
            default:        w_wait_val = 24'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_load_req  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_state_nxt = S_REQ;
                    w_step_nxt  = 5'd0;
                    w_load_req  = 1'b1;
                end
            end
            S_REQ: begin
                // An ack on the expiring cycle still wins over the timeout
                if (i_wb_ack) begin
                    w_state_nxt = S_GAP;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_GAP: begin
                if (r_wait <= 24'd1) begin
                    if (r_step == LAST_STEP) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_step_nxt  = r_step + 5'd1;
                        w_load_req  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_adr   <= 30'd0;
            r_wb_dat   <= 32'd0;
            r_wait_sel <= WAIT_NONE;
            r_wait     <= 24'd0;
            r_timeout  <= 16'd0;
        end else begin
            if (w_load_req) begin
                r_wb_adr   <= reg_word_adr(DFII_BASE, w_entry.sel);
                r_wb_dat   <= w_entry.data;
                r_wait_sel <= w_entry.wait_sel;
                r_timeout  <= 16'd0;
            end else if ((r_state == S_REQ) && (r_timeout != 16'hFFFF)) begin
                r_timeout <= r_timeout + 16'd1;
            end

            if ((r_state == S_REQ) && i_wb_ack) begin
                r_wait <= w_wait_val;
            end else if ((r_state == S_GAP) && (r_wait != 24'd0)) begin
                r_wait <= r_wait - 24'd1;
            end
        end
    end

    assign o_wb_cyc   = (r_state == S_REQ);
    assign o_wb_stb   = o_wb_cyc;
    assign o_wb_we    = o_wb_cyc;
    assign o_wb_sel   = o_wb_cyc ? 4'hF : 4'h0;
    assign o_wb_adr   = r_wb_adr;
    assign o_wb_dat_w = r_wb_dat;
    assign o_busy     = (r_state == S_REQ) || (r_state == S_GAP);
    assign o_done     = (r_state == S_DONE);
    assign o_error    = (r_state == S_ERROR);
    assign o_step     = r_step;

endmodule

`default_nettype wire

// File: tb/tb_dfii_init_sequencer.sv
// ============================================================================
// Module   : tb_dfii_init_sequencer
// Brief    : Scoreboard bench for the DFII power-up sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dfii_init_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [4:0]  o_step;
    logic [29:0] o_wb_adr;
    logic [31:0] o_wb_dat_w;
    logic [3:0]  o_wb_sel;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic        i_wb_ack;

    always #5 clk = ~clk;

    dfii_init_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_step     (o_step),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat_w (o_wb_dat_w),
        .o_wb_sel   (o_wb_sel),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .i_wb_ack   (i_wb_ack)
    );

    typedef struct packed {
        logic [29:0] adr;
        logic [31:0] dat;
    } wr_t;

    // Hand-derived write list: word address = 0x2400 + register offset/4
    localparam logic [29:0] EXP_ADR [29] = '{
        30'h2403, 30'h2404, 30'h2400, 30'h2400,
        30'h2403, 30'h2404, 30'h2401, 30'h2402,
        30'h2403, 30'h2404, 30'h2401, 30'h2402,
        30'h2403, 30'h2404, 30'h2401, 30'h2402,
        30'h2403, 30'h2404, 30'h2401, 30'h2402,
        30'h2403, 30'h2404, 30'h2401, 30'h2402,
        30'h2403, 30'h2404, 30'h2401, 30'h2402,
        30'h2400
    };
    localparam logic [31:0] EXP_DAT [29] = '{
        32'h000, 32'h000, 32'h00C, 32'h00E,
        32'h200, 32'h002, 32'h00F, 32'h001,
        32'h000, 32'h003, 32'h00F, 32'h001,
        32'h006, 32'h001, 32'h00F, 32'h001,
        32'h320, 32'h000, 32'h00F, 32'h001,
        32'h220, 32'h000, 32'h00F, 32'h001,
        32'h400, 32'h000, 32'h003, 32'h001,
        32'h001
    };

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  writes = 0;
    int  gap_after [32];
    bit  gap_armed = 1'b0;
    int  gap_cnt   = 0;
    int  last_step = 0;
    bit  rand_mode = 1'b0;
    int  fixed_delay = 1;
    int  hang_step = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{adr: EXP_ADR[i], dat: EXP_DAT[i]});
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc, input bit spam, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (!o_busy) i_start = 1'b0;
            if (o_done || o_error) begin
                ok = 1'b1;
                break;
            end
            if (spam) i_start = ($urandom_range(0, 3) == 0);
        end
        i_start = 1'b0;
    endtask

    task automatic wait_req_step(input int stp, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (o_wb_cyc && (int'(o_step) == stp)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Slave: raises ack a programmable number of cycles into each request
    initial begin
        int ack_cnt;
        int cur_delay;
        i_wb_ack  = 1'b0;
        ack_cnt   = 0;
        cur_delay = 1;
        forever begin
            @(posedge clk);
            #2;
            if (o_wb_cyc && o_wb_stb && (int'(o_step) != hang_step)) begin
                i_wb_ack = (ack_cnt == cur_delay);
                ack_cnt++;
            end else begin
                i_wb_ack  = 1'b0;
                ack_cnt   = 0;
                cur_delay = rand_mode ? int'($urandom_range(0, 20)) : fixed_delay;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted write and measures idle gaps
    initial begin
        bit          in_req;
        bit          stable;
        logic [29:0] hold_adr;
        logic [31:0] hold_dat;
        wr_t         e;
        in_req = 1'b0;
        stable = 1'b1;
        hold_adr = '0;
        hold_dat = '0;
        forever begin
            @(negedge clk);
            if (o_wb_cyc) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    stable   = 1'b1;
                    hold_adr = o_wb_adr;
                    hold_dat = o_wb_dat_w;
                    if (gap_armed) gap_after[last_step] = gap_cnt;
                    gap_armed = 1'b0;
                end else if ((o_wb_adr !== hold_adr) || (o_wb_dat_w !== hold_dat)) begin
                    stable = 1'b0;
                end
                if (i_wb_ack) begin
                    checks++;
                    writes++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL write_unexpected: got adr 0x%0h dat 0x%0h expected none", o_wb_adr, o_wb_dat_w);
                    end else begin
                        e = exp_q.pop_front();
                        if ((o_wb_adr !== e.adr) || (o_wb_dat_w !== e.dat) || !stable ||
                            (o_wb_sel !== 4'hF) || (o_wb_we !== 1'b1) || (o_wb_stb !== 1'b1)) begin
                            errors++;
                            $display("FAIL write_step%0d: got adr 0x%0h dat 0x%0h sel 0x%0h we %0b stable %0b expected adr 0x%0h dat 0x%0h sel 0xf we 1 stable 1",
                                     o_step, o_wb_adr, o_wb_dat_w, o_wb_sel, o_wb_we, stable, e.adr, e.dat);
                        end
                    end
                    in_req    = 1'b0;
                    last_step = int'(o_step);
                    gap_cnt   = 0;
                    gap_armed = 1'b1;
                end
            end else begin
                in_req = 1'b0;
                if (gap_armed) gap_cnt++;
            end
        end
    end

    initial begin
        bit ok;
        int n;
        rst_n   = 1'b0;
        i_start = 1'b0;
        for (int i = 0; i < 32; i++) gap_after[i] = -1;

        repeat (3) @(negedge clk);
        chk("reset_strobes", 32'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}), 32'h0);
        chk("reset_adr", 32'(o_wb_adr), 32'h0);
        chk("reset_dat", o_wb_dat_w, 32'h0);
        chk("reset_status", 32'({o_busy, o_done, o_error, o_step}), 32'h0);
        rst_n = 1'b1;

        // Happy path with ack one cycle into each request
        push_exp(29);
        writes = 0;
        pulse_start();
        chk("start_busy_cyc", 32'({o_busy, o_wb_cyc, o_wb_stb}), 32'h7);
        wait_end(5000, 1'b0, ok);
        chk("happy_end_reached", 32'(ok), 32'h1);
        chk("happy_status", 32'({o_busy, o_done, o_error, o_wb_cyc}), 32'h4);
        chk("happy_write_count", 32'(writes), 32'd29);
        chk("happy_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("happy_last_step", 32'(o_step), 32'd28);
        chk("gap_b2b", 32'(gap_after[0]), 32'd1);
        chk("gap_T_RESET", 32'(gap_after[2]), 32'd50);
        chk("gap_T_CKE", 32'(gap_after[3]), 32'd50);
        chk("gap_T_DLLK", 32'(gap_after[23]), 32'd600);
        chk("gap_T_ZQINIT", 32'(gap_after[27]), 32'd600);
        repeat (5) @(negedge clk);
        chk("done_held", 32'({o_done, o_busy}), 32'h2);

        // Slow slave with random ack delay and start spammed while busy
        rand_mode = 1'b1;
        push_exp(29);
        writes = 0;
        pulse_start();
        wait_end(20000, 1'b1, ok);
        chk("slow_end_reached", 32'(ok), 32'h1);
        chk("slow_status", 32'({o_busy, o_done, o_error, o_wb_cyc}), 32'h4);
        chk("slow_write_count", 32'(writes), 32'd29);
        chk("slow_queue_empty", 32'(exp_q.size()), 32'd0);
        rand_mode = 1'b0;

        // Slave never acks step 5
        fixed_delay = 1;
        hang_step   = 5;
        push_exp(5);
        writes = 0;
        pulse_start();
        wait_req_step(5, 500, ok);
        chk("timeout_reach_step5", 32'(ok), 32'h1);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            n++;
            if (o_error) break;
        end
        chk("timeout_cycles", 32'(n), 32'd1024);
        chk("timeout_status", 32'({o_busy, o_done, o_error, o_wb_cyc}), 32'h2);
        chk("timeout_step", 32'(o_step), 32'd5);
        chk("timeout_writes", 32'(writes), 32'd5);
        repeat (3) @(negedge clk);
        chk("error_held", 32'({o_error, o_wb_cyc}), 32'h2);
        hang_step = -1;

        // Replay from error
        gap_armed = 1'b0;
        push_exp(29);
        writes = 0;
        pulse_start();
        chk("replay1_first_adr", 32'(o_wb_adr), 32'h2403);
        wait_end(5000, 1'b0, ok);
        chk("replay1_status", 32'({o_busy, o_done, o_error, o_wb_cyc}), 32'h4);
        chk("replay1_write_count", 32'(writes), 32'd29);

        // Reset asserted while step 10 is on the bus
        fixed_delay = 20;
        gap_armed = 1'b0;
        push_exp(10);
        writes = 0;
        pulse_start();
        wait_req_step(10, 1000, ok);
        chk("reset_reach_step10", 32'(ok), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_strobes", 32'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}), 32'h0);
        chk("midrst_adr_dat", 32'(o_wb_adr) | o_wb_dat_w, 32'h0);
        chk("midrst_status", 32'({o_busy, o_done, o_error, o_step}), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_restart", 32'({o_busy, o_wb_cyc}), 32'h0);
        chk("midrst_writes", 32'(writes), 32'd10);
        chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

        // Replay after reset
        fixed_delay = 1;
        gap_armed = 1'b0;
        push_exp(29);
        writes = 0;
        pulse_start();
        chk("replay2_first_write", 32'(o_wb_adr) ^ o_wb_dat_w, 32'h2403);
        wait_end(5000, 1'b0, ok);
        chk("replay2_status", 32'({o_busy, o_done, o_error, o_wb_cyc}), 32'h4);
        chk("replay2_write_count", 32'(writes), 32'd29);
        chk("replay2_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dfii_init_sequencer.md
# dfii_init_sequencer

Hardware DDR3 power-up sequencer that replaces software DFII bring-up: a Wishbone classic master that writes the DFII CSR block of the gram controller. It releases reset, enables CKE and programs MR2/MR3/MR1/MR0, including the DLL-reset pass. It then issues ZQCL and hands the PHY to the hardware controller by setting DFII_CONTROL_SEL. It sits between the SoC reset/start logic and the controller's CSR Wishbone port, ahead of any CPU access.

## Interface
- DFII_BASE, 32'h0000_9000: byte address of DFII control register.
- MR0_DLLRST, 14'h320: MR0 value with DLL reset; MR0, 14'h220: MR0 final value.
- MR1, 14'h006; MR2, 14'h200; MR3, 14'h000.
- T_RESET, 24'd50: cycles after RESET_N release before CKE.
- T_CKE, 24'd50: cycles after CKE before first MRS.
- T_DLLK, 24'd600: cycles after final MR0.
- T_ZQINIT, 24'd600: cycles after ZQCL.
- ACK_TIMEOUT, 16'd1024: max cycles waiting for wb_ack.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  pulse/level; begins sequence when idle, done or error.
- busy  out  1  sequence in progress.
- done  out  1  sequence completed; held until next start or reset.
- error  out  1  ack timeout; held until next start or reset.
- step  out  5  index of current/last step (debug).
- wb_adr  out  30  word address (byte address >> 2).
- wb_dat_w  out  32  write data.
- wb_sel  out  4  always 4'hF during a cycle.
- wb_cyc, wb_stb, wb_we  out  1 each  Wishbone classic strobes; we=1 whenever cyc=1.
- wb_ack  in  1  Wishbone acknowledge.

## Operation
- Registers (byte offsets from DFII_BASE): CONTROL +0x0, COMMAND +0x4, ISSUE +0x8, ADDRESS +0xC, BADDRESS +0x10.
- Step table, 29 writes, `(offset, data, post-wait)`:
  - 0: ADDRESS←0.
  - 1: BADDRESS←0.
  - 2: CONTROL←0x0C (ODT|RESET_N), wait T_RESET.
  - 3: CONTROL←0x0E (+CKE), wait T_CKE.
- Each MRS is 4 writes: ADDRESS←value, BADDRESS←ba, COMMAND←0x0F, ISSUE←0x01.
  - 4–7: MR2, ba 2.
  - 8–11: MR3, ba 3.
  - 12–15: MR1, ba 1.
  - 16–19: MR0_DLLRST, ba 0.
  - 20–23: MR0, ba 0; post-wait T_DLLK on step 23.
- ZQCL, 24–27: ADDRESS←0x400, BADDRESS←0, COMMAND←0x03, ISSUE←0x01; post-wait T_ZQINIT on step 27.
- 28: CONTROL←0x01 (SEL); then DONE.
- FSM states:
  - IDLE: start → REQ with step=0.
  - REQ: cyc=stb=we=1. On wb_ack, go to GAP; on timeout, go to ERROR.
  - GAP: cyc=0. If step=28 → DONE, else step+1 → REQ after the gap.
  - DONE, ERROR: start → REQ with step=0.
- Timeout counter cleared on REQ entry, increments each REQ cycle. Reaching ACK_TIMEOUT without ack → ERROR, cyc dropped.
- start is ignored while busy.

## Timing
- Reset values:
  - All wb_* strobes 0, wb_adr 0, wb_dat_w 0, wb_sel 0.
  - busy=0, done=0, error=0, step=0, state IDLE.
- All outputs are registered or decoded from registered state; no combinational path wb_ack→wb_cyc.
- start high at edge k in IDLE → cyc/stb=1 and busy=1 from cycle k+1.
- wb_ack sampled at edge n → cyc/stb=0 in cycle n+1.
- Gap length with cyc=0 is max(1, post-wait) cycles, so back-to-back writes have exactly 1 idle cycle.
- wb_adr and wb_dat_w are stable for the whole REQ phase.
- done/error assert with cyc=0 in the same cycle busy deasserts.
- Wait counter: 24-bit down-counter, loaded on ack, no wrap.
- Timeout counter: 16-bit, saturating.
- rst_n low mid-transaction → cyc/stb drop at the next edge; the sequence restarts only on a new start.
- ack arriving on the same edge the timeout expires counts as success.

## Structure
- Shared package holds:
  - DFII register offsets.
  - CONTROL bits: SEL=0x01, CKE=0x02, ODT=0x04, RESET_N=0x08.
  - COMMAND bits: CS=0x01, WE=0x02, CAS=0x04, RAS=0x08.
  - Step-entry encoding: 3-bit register select, 32-bit data, 2-bit wait select {none, T_RESET/T_CKE, T_DLLK, T_ZQINIT}.
- Sub-module dfii_init_rom: combinational step-index → entry, parameterised by the MR values.

## Test plan
- Happy path, slave acks 1 cycle after stb:
  - 29 writes in table order.
  - First write is wb_adr=0x2403, data 0.
  - Last write is wb_adr=0x2400, data 0x01.
  - done=1, busy=0 afterwards.
- Wait checks:
  - Cycles between the ack of step 23 and stb of step 24 equal T_DLLK (600).
  - Cycles between the ack of step 27 and stb of step 28 equal T_ZQINIT (600).
  - Cycles between the ack of step 2 and stb of step 3 equal T_RESET (50).
- Slow slave with random 0–20 cycle ack delay → wb_adr/wb_dat_w stable throughout stb; sequence identical; no error.
- Slave never acks step 5 → error=1 at ACK_TIMEOUT cycles after stb; cyc=0; step=5. A new start then replays from step 0.
- rst_n asserted during step 10 → all outputs return to reset values next cycle. start then replays from step 0, and the first write is ADDRESS←0.
- start pulsed repeatedly while busy → no effect on order or count of writes.
